// File: rtl/sevenseg_pkg.sv
// Shared seven-segment table for the display driver and the read-back monitor.
// Patterns are {g,f,e,d,c,b,a}, active-high, bit0 = a.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] VALUE_BLANK   = 4'd12;
  localparam logic [3:0] VALUE_INVALID = 4'd15;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } mon_state_e;

  function automatic logic [3:0] seg_to_value(input logic [6:0] seg);
    logic [3:0] v;
    case (seg)
      SEG_0:     v = 4'd0;
      SEG_1:     v = 4'd1;
      SEG_2:     v = 4'd2;
      SEG_3:     v = 4'd3;
      SEG_4:     v = 4'd4;
      SEG_5:     v = 4'd5;
      SEG_6:     v = 4'd6;
      SEG_7:     v = 4'd7;
      SEG_8:     v = 4'd8;
      SEG_9:     v = 4'd9;
      SEG_BLANK: v = VALUE_BLANK;
      default:   v = VALUE_INVALID;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sevenseg_stable_filter.sv
// Glitch filter for the segment bus: registers the bus, tracks a candidate
// pattern and strobes commit on the edge its run length reaches STABLE_CYCLES.
module sevenseg_stable_filter
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_i,
  output logic       commit_o,
  output logic [6:0] pattern_o
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    samp_q, samp_d;
  logic          samp_vld_q, samp_vld_d;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit_s;

  // Candidate tracking; samp_vld_q keeps the reset value of samp from counting as a sample.
  always_comb begin
    samp_d     = seg_i;
    samp_vld_d = 1'b1;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    if (!samp_vld_q) begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
    end else if (samp_q != cand_q) begin
      cand_d = samp_q;
      cnt_d  = CW'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // A fresh candidate can commit immediately when STABLE_CYCLES is 1.
    commit_s = samp_vld_q && (cnt_d == CNT_MAX) &&
               ((cnt_q != CNT_MAX) || (samp_q != cand_q));
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q     <= SEG_BLANK;
      samp_vld_q <= 1'b0;
      cand_q     <= SEG_BLANK;
      cnt_q      <= '0;
    end else begin
      samp_q     <= samp_d;
      samp_vld_q <= samp_vld_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
    end
  end

  assign commit_o  = commit_s;
  assign pattern_o = cand_d;

endmodule

// File: rtl/sevenseg_monitor.sv
// Seven-segment read-back monitor: decodes filtered stable patterns, reports
// value changes through a one-entry event register and counts them.
module sevenseg_monitor
  import sevenseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       clear,
  output logic [3:0] value,
  output logic       locked,
  output logic       invalid,
  output logic       evt_valid,
  output logic [3:0] evt_value,
  input  logic       evt_ready,
  output logic       overflow,
  output logic [7:0] change_count
);

  logic       commit_s;
  logic [6:0] pattern_s;
  logic [3:0] dec_value_s;
  logic       change_s;
  logic       drop_s;

  mon_state_e state_q, state_d;
  logic       locked_s;

  logic [3:0] value_q, value_d;
  logic       invalid_q, invalid_d;
  logic       evt_valid_q, evt_valid_d;
  logic [3:0] evt_value_q, evt_value_d;
  logic       overflow_q, overflow_d;
  logic [7:0] chg_cnt_q, chg_cnt_d;

  sevenseg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .seg_i    (seg_in),
    .commit_o (commit_s),
    .pattern_o(pattern_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: the first commit locks, only reset unlocks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (commit_s) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_UNLOCKED;
    endcase
  end

  // FSM output decode.
  always_comb begin
    locked_s = (state_q == ST_LOCKED);
  end

  // Decode, change detection, event holding register and change counter.
  always_comb begin
    dec_value_s = seg_to_value(pattern_s);
    change_s    = commit_s && ((state_q == ST_UNLOCKED) || (dec_value_s != value_q));
    drop_s      = change_s && evt_valid_q && !evt_ready;

    value_d     = value_q;
    invalid_d   = invalid_q;
    evt_valid_d = evt_valid_q;
    evt_value_d = evt_value_q;
    overflow_d  = overflow_q;
    chg_cnt_d   = chg_cnt_q;

    if (commit_s) begin
      value_d   = dec_value_s;
      invalid_d = (dec_value_s == VALUE_INVALID);
    end else begin
      value_d   = value_q;
      invalid_d = invalid_q;
    end

    if (change_s && !drop_s) begin
      evt_valid_d = 1'b1;
      evt_value_d = dec_value_s;
    end else if (!change_s && evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end

    // Clear wins over the sticky history but still records this cycle's activity.
    if (clear) begin
      overflow_d = drop_s;
      chg_cnt_d  = change_s ? 8'd1 : 8'd0;
    end else begin
      overflow_d = overflow_q | drop_s;
      if (change_s && (chg_cnt_q != 8'd255)) begin
        chg_cnt_d = chg_cnt_q + 8'd1;
      end else begin
        chg_cnt_d = chg_cnt_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q     <= VALUE_BLANK;
      invalid_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_value_q <= 4'd0;
      overflow_q  <= 1'b0;
      chg_cnt_q   <= 8'd0;
    end else begin
      value_q     <= value_d;
      invalid_q   <= invalid_d;
      evt_valid_q <= evt_valid_d;
      evt_value_q <= evt_value_d;
      overflow_q  <= overflow_d;
      chg_cnt_q   <= chg_cnt_d;
    end
  end

  assign value        = value_q;
  assign locked       = locked_s;
  assign invalid      = invalid_q;
  assign evt_valid    = evt_valid_q;
  assign evt_value    = evt_value_q;
  assign overflow     = overflow_q;
  assign change_count = chg_cnt_q;

endmodule

// File: tb/tb_sevenseg_monitor.sv
// Directed bench for sevenseg_monitor (STABLE_CYCLES = 4); inputs change and
// outputs are checked on the falling edge.
module tb_sevenseg_monitor;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic       clear;
  logic [3:0] value;
  logic       locked;
  logic       invalid;
  logic       evt_valid;
  logic [3:0] evt_value;
  logic       evt_ready;
  logic       overflow;
  logic [7:0] change_count;

  int checks;
  int failures;

  sevenseg_monitor #(
    .STABLE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .clear       (clear),
    .value       (value),
    .locked      (locked),
    .invalid     (invalid),
    .evt_valid   (evt_valid),
    .evt_value   (evt_value),
    .evt_ready   (evt_ready),
    .overflow    (overflow),
    .change_count(change_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_value"}, {4'd0, value}, 8'd12);
    chk({tag, "_locked"}, {7'd0, locked}, 8'd0);
    chk({tag, "_invalid"}, {7'd0, invalid}, 8'd0);
    chk({tag, "_evt_valid"}, {7'd0, evt_valid}, 8'd0);
    chk({tag, "_evt_value"}, {4'd0, evt_value}, 8'd0);
    chk({tag, "_overflow"}, {7'd0, overflow}, 8'd0);
    chk({tag, "_count"}, change_count, 8'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    seg_in    = 7'h00;
    clear     = 1'b0;
    evt_ready = 1'b0;
    tick(3);
    chk_reset_vals("rst");

    // Blank held from reset release: commits on the fifth edge, not the fourth.
    reset = 1'b0;
    tick(4);
    chk("blank_early_locked", {7'd0, locked}, 8'd0);
    tick(1);
    chk("blank_value", {4'd0, value}, 8'd12);
    chk("blank_locked", {7'd0, locked}, 8'd1);
    chk("blank_evt_valid", {7'd0, evt_valid}, 8'd1);
    chk("blank_evt_value", {4'd0, evt_value}, 8'd12);
    chk("blank_count", change_count, 8'd1);
    evt_ready = 1'b1;
    tick(1);
    chk("blank_consumed", {7'd0, evt_valid}, 8'd0);
    evt_ready = 1'b0;

    // 3F held, then a 3-cycle blip of 06 must not commit.
    seg_in = 7'h3F;
    tick(10);
    chk("zero_value", {4'd0, value}, 8'd0);
    chk("zero_count", change_count, 8'd2);
    chk("zero_evt_value", {4'd0, evt_value}, 8'd0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    seg_in = 7'h06;
    tick(3);
    seg_in = 7'h3F;
    tick(8);
    chk("blip_value", {4'd0, value}, 8'd0);
    chk("blip_count", change_count, 8'd2);
    chk("blip_evt_valid", {7'd0, evt_valid}, 8'd0);

    // Clear, then 5B and 4F accepted in order with ready high.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear1_count", change_count, 8'd0);
    evt_ready = 1'b1;
    seg_in = 7'h5B;
    tick(5);
    chk("two_evt_valid", {7'd0, evt_valid}, 8'd1);
    chk("two_evt_value", {4'd0, evt_value}, 8'd2);
    tick(3);
    chk("two_drained", {7'd0, evt_valid}, 8'd0);
    seg_in = 7'h4F;
    tick(5);
    chk("three_evt_valid", {7'd0, evt_valid}, 8'd1);
    chk("three_evt_value", {4'd0, evt_value}, 8'd3);
    tick(3);
    chk("three_value", {4'd0, value}, 8'd3);
    chk("three_overflow", {7'd0, overflow}, 8'd0);
    chk("three_count", change_count, 8'd2);

    // Ready low: 8 is held, 9 is dropped and sets overflow.
    evt_ready = 1'b0;
    seg_in = 7'h7F;
    tick(5);
    chk("eight_evt_value", {4'd0, evt_value}, 8'd8);
    tick(3);
    seg_in = 7'h6F;
    tick(5);
    chk("nine_value", {4'd0, value}, 8'd9);
    chk("nine_evt_value", {4'd0, evt_value}, 8'd8);
    chk("nine_overflow", {7'd0, overflow}, 8'd1);
    chk("nine_count", change_count, 8'd4);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("nine_consumed", {7'd0, evt_valid}, 8'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear2_overflow", {7'd0, overflow}, 8'd0);
    chk("clear2_count", change_count, 8'd0);

    // Change while pending with ready high on the commit edge: reload, no overflow.
    seg_in = 7'h3F;
    tick(8);
    seg_in = 7'h06;
    tick(4);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("reload_evt_valid", {7'd0, evt_valid}, 8'd1);
    chk("reload_evt_value", {4'd0, evt_value}, 8'd1);
    chk("reload_overflow", {7'd0, overflow}, 8'd0);
    chk("reload_count", change_count, 8'd2);

    // Clear on the same edge as a dropped change: count 1, overflow 1.
    seg_in = 7'h5B;
    tick(4);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clrchg_count", change_count, 8'd1);
    chk("clrchg_overflow", {7'd0, overflow}, 8'd1);
    chk("clrchg_evt_value", {4'd0, evt_value}, 8'd1);
    chk("clrchg_value", {4'd0, value}, 8'd2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;

    // Invalid pattern 49 (a,d,g), then back to 0.
    seg_in = 7'h49;
    tick(5);
    chk("inv_value", {4'd0, value}, 8'd15);
    chk("inv_flag", {7'd0, invalid}, 8'd1);
    chk("inv_evt_value", {4'd0, evt_value}, 8'd15);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    seg_in = 7'h3F;
    tick(5);
    chk("valid_again_flag", {7'd0, invalid}, 8'd0);
    chk("valid_again_value", {4'd0, value}, 8'd0);

    // 300 alternating stable patterns saturate the counter at 255.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      seg_in = (i % 2 == 0) ? 7'h06 : 7'h3F;
      tick(5);
    end
    chk("sat_255", change_count, 8'd255);
    for (int i = 255; i < 300; i++) begin
      seg_in = (i % 2 == 0) ? 7'h06 : 7'h3F;
      tick(5);
    end
    chk("sat_300", change_count, 8'd255);

    // Reset mid-settle with an event pending.
    evt_ready = 1'b0;
    seg_in = 7'h66;
    tick(5);
    chk("pre_rst_evt_valid", {7'd0, evt_valid}, 8'd1);
    seg_in = 7'h5B;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk_reset_vals("midrst");
    reset = 1'b0;
    tick(4);
    chk("post_rst_early_locked", {7'd0, locked}, 8'd0);
    tick(1);
    chk("post_rst_locked", {7'd0, locked}, 8'd1);
    chk("post_rst_value", {4'd0, value}, 8'd2);
    chk("post_rst_count", change_count, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
